// File: rtl/bus_fifo_responder.sv
// bus_fifo_responder: memory-mapped bus target with a DEPTH-word FIFO and
// status/control/threshold registers in a 4-word window. Only the current
// bus owner's strobes are honoured. Read data is returned on the shared bus
// in the cycle after the read is sampled.
module bus_fifo_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
    parameter int          DEPTH     = 16,
    parameter int          PTR_W     = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ADE,
    input  logic [31:0] address_Bus,
    inout  wire  [31:0] Data_Bus,
    input  logic        Read_DMA,
    input  logic        Write_DMA,
    input  logic        Read_CPU,
    input  logic        Write_CPU,
    output logic        irq
);

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_THRESH = 2'd3;

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;
    logic [PTR_W:0]   thresh;
    logic             overflow;
    logic             underflow;
    logic             drive_q;
    logic [31:0]      rdata_q;

    logic             rd_eff;
    logic             wr_eff;
    logic             hit;
    logic [1:0]       offset;
    logic             wr_acc;
    logic             rd_acc;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             overflow_hit;
    logic             underflow_hit;
    logic             flush;
    logic             clear_flags;
    logic             thresh_wr;
    logic [31:0]      status_word;
    logic [31:0]      read_value;

    // The bus is only driven during the read-return cycle; reset releases it at once.
    assign Data_Bus = drive_q ? rdata_q : 32'bz;

    // Decode the owner's strobes into a single access and its effect on the FIFO/registers.
    always_comb begin
        rd_eff        = ADE ? Read_DMA  : Read_CPU;
        wr_eff        = ADE ? Write_DMA : Write_CPU;
        hit           = (address_Bus[31:2] == BASE_ADDR[31:2]);
        offset        = address_Bus[1:0];
        wr_acc        = wr_eff && hit;
        rd_acc        = rd_eff && hit && !wr_eff;
        empty         = (count == '0);
        full          = (count == (PTR_W+1)'(DEPTH));
        push          = wr_acc && (offset == OFF_DATA) && !full;
        overflow_hit  = wr_acc && (offset == OFF_DATA) && full;
        pop           = rd_acc && (offset == OFF_DATA) && !empty;
        underflow_hit = rd_acc && (offset == OFF_DATA) && empty;
        flush         = wr_acc && (offset == OFF_CTRL) && Data_Bus[0];
        clear_flags   = wr_acc && (offset == OFF_CTRL) && Data_Bus[1];
        thresh_wr     = wr_acc && (offset == OFF_THRESH);

        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (push) begin
            count_next = count + 1'b1;
        end else if (pop) begin
            count_next = count - 1'b1;
        end

        status_word = {16'h0000, 8'(count), 3'b000, irq, underflow, overflow, full, empty};

        read_value = 32'h0;
        case (offset)
            OFF_DATA:   read_value = empty ? 32'h0 : mem[rd_ptr];
            OFF_STATUS: read_value = status_word;
            OFF_CTRL:   read_value = 32'h0;
            OFF_THRESH: read_value = 32'(thresh);
            default:    read_value = 32'h0;
        endcase
    end

    // FIFO storage has no reset; flushing only moves the pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= Data_Bus;
        end
    end

    // Pointers, count, sticky flags, threshold, read return and interrupt.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            thresh    <= (PTR_W+1)'(DEPTH / 2);
            rdata_q   <= 32'h0;
            drive_q   <= 1'b0;
            irq       <= 1'b0;
        end else begin
            count <= count_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
            if (clear_flags) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (overflow_hit) begin
                    overflow <= 1'b1;
                end
                if (underflow_hit) begin
                    underflow <= 1'b1;
                end
            end
            if (thresh_wr) begin
                thresh <= Data_Bus[PTR_W:0];
            end
            drive_q <= rd_acc;
            if (rd_acc) begin
                rdata_q <= read_value;
            end
            irq <= (count_next >= thresh) && (thresh != '0);
        end
    end

endmodule

// File: tb/tb_bus_fifo_responder.sv
// tb_bus_fifo_responder: directed scenarios plus randomized bus traffic,
// checked every cycle against a queue-based model of the responder.
module tb_bus_fifo_responder;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clock;
    logic        reset_n;
    logic        ade;
    logic [31:0] address_bus;
    wire  [31:0] data_bus;
    logic        read_dma;
    logic        write_dma;
    logic        read_cpu;
    logic        write_cpu;
    logic        irq;

    logic        tb_drive_en;
    logic [31:0] tb_data;

    int n_checks;
    int n_errors;

    logic [31:0] m_queue[$];
    bit          m_ovf;
    bit          m_unf;
    bit          m_irq;
    bit          m_drive;
    logic [31:0] m_rdata;
    int          m_thresh;

    assign data_bus = tb_drive_en ? tb_data : 32'bz;

    bus_fifo_responder #(
        .BASE_ADDR(BASE),
        .DEPTH(16),
        .PTR_W(4)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .ADE(ade),
        .address_Bus(address_bus),
        .Data_Bus(data_bus),
        .Read_DMA(read_dma),
        .Write_DMA(write_dma),
        .Read_CPU(read_cpu),
        .Write_CPU(write_cpu),
        .irq(irq)
    );

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_queue.delete();
        m_ovf    = 0;
        m_unf    = 0;
        m_irq    = 0;
        m_drive  = 0;
        m_rdata  = 32'h0;
        m_thresh = 8;
    endtask

    task automatic modelStep(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] dat);
        bit          hit;
        int          off;
        int          old_thresh;
        logic [31:0] old_status;
        hit        = ((addr >> 2) == (BASE >> 2));
        off        = int'(addr % 4);
        old_thresh = m_thresh;
        old_status = 32'h0;
        old_status[0]    = (m_queue.size() == 0);
        old_status[1]    = (m_queue.size() == 16);
        old_status[2]    = m_ovf;
        old_status[3]    = m_unf;
        old_status[4]    = m_irq;
        old_status[15:8] = 8'(m_queue.size());
        m_drive = 0;
        if (hit && wr) begin
            if (off == 0) begin
                if (m_queue.size() < 16) m_queue.push_back(dat);
                else m_ovf = 1;
            end else if (off == 2) begin
                if (dat[0]) m_queue.delete();
                if (dat[1]) begin
                    m_ovf = 0;
                    m_unf = 0;
                end
            end else if (off == 3) begin
                m_thresh = int'(dat % 32);
            end
        end else if (hit && rd) begin
            m_drive = 1;
            if (off == 0) begin
                if (m_queue.size() > 0) m_rdata = m_queue.pop_front();
                else begin
                    m_rdata = 32'h0;
                    m_unf   = 1;
                end
            end else if (off == 1) m_rdata = old_status;
            else if (off == 2)     m_rdata = 32'h0;
            else                   m_rdata = 32'(old_thresh);
        end
        m_irq = (m_queue.size() >= old_thresh) && (old_thresh != 0);
    endtask

    // Drives one bus cycle, advances the model at the edge, then re-drives the probe value.
    task automatic applyStimulus(input bit a, input bit rdd, input bit wrd, input bit rdc, input bit wrc,
                                 input logic [31:0] addr, input logic [31:0] dat);
        bit rd;
        bit wr;
        bit hit;
        ade         = a;
        read_dma    = rdd;
        write_dma   = wrd;
        read_cpu    = rdc;
        write_cpu   = wrc;
        address_bus = addr;
        rd  = a ? rdd : rdc;
        wr  = a ? wrd : wrc;
        hit = ((addr >> 2) == (BASE >> 2));
        tb_data     = dat;
        tb_drive_en = !m_drive && !(rd && hit && !wr);
        @(posedge clock);
        if (reset_n) modelStep(rd, wr, addr, dat);
        #1;
        tb_drive_en = !m_drive;
        tb_data     = $urandom;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 32'h0, $urandom);
    endtask

    task automatic busWrite(input bit a, input logic [31:0] addr, input logic [31:0] dat);
        if (m_drive) idleCycle();
        applyStimulus(a, 0, a, 0, !a, addr, dat);
    endtask

    task automatic busRead(input bit a, input logic [31:0] addr);
        applyStimulus(a, a, 0, !a, 0, addr, $urandom);
    endtask

    // Every cycle: irq against the model, the bus against the read return or the released probe.
    always @(posedge clock) begin
        #2;
        checkOutput("irq", {31'b0, irq}, {31'b0, m_irq});
        if (m_drive) checkOutput("read_return", data_bus, m_rdata);
        else if (tb_drive_en) checkOutput("bus_released", data_bus, tb_data);
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset_n     = 1'b0;
        ade         = 1'b0;
        address_bus = 32'h0;
        read_dma    = 1'b0;
        write_dma   = 1'b0;
        read_cpu    = 1'b0;
        write_cpu   = 1'b0;
        tb_drive_en = 1'b1;
        tb_data     = 32'h0;
        modelReset();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        $display("[TB] reset status read");
        busRead(0, BASE + 1);
        checkOutput("reset_status", data_bus, 32'h0000_0001);

        $display("[TB] DMA fill and overflow");
        for (int i = 0; i < 16; i++) busWrite(1, BASE, 32'hA000_0000 + 32'(i));
        busWrite(1, BASE, 32'hDEAD_BEEF);
        busRead(1, BASE + 1);
        checkOutput("full_status", data_bus, 32'h0000_1016);

        $display("[TB] CPU drain and underflow");
        busWrite(0, BASE + 2, 32'h2);
        for (int i = 0; i < 16; i++) begin
            busRead(0, BASE);
            checkOutput("drain_data", data_bus, 32'hA000_0000 + 32'(i));
        end
        busRead(0, BASE);
        checkOutput("underflow_data", data_bus, 32'h0);
        busRead(0, BASE + 1);
        checkOutput("underflow_status", data_bus, 32'h0000_0009);

        $display("[TB] non-owner strobe and irq threshold");
        idleCycle();
        applyStimulus(1, 0, 0, 0, 1, BASE, 32'h1234_5678);
        busRead(1, BASE + 1);
        checkOutput("nonowner_status", data_bus, 32'h0000_0009);
        busWrite(1, BASE + 3, 32'hFFFF_FFE3);
        busWrite(1, BASE, 32'h5000_0000);
        busWrite(1, BASE, 32'h5000_0001);
        checkOutput("irq_below", {31'b0, irq}, 32'h0);
        busWrite(1, BASE, 32'h5000_0002);
        checkOutput("irq_rise", {31'b0, irq}, 32'h1);
        busRead(1, BASE);
        checkOutput("irq_pop_data", data_bus, 32'h5000_0000);
        checkOutput("irq_fall", {31'b0, irq}, 32'h0);
        busRead(1, BASE + 3);
        checkOutput("thresh_read", data_bus, 32'h0000_0003);

        $display("[TB] pointer wrap");
        busWrite(0, BASE + 2, 32'h1);
        for (int i = 0; i < 10; i++) busWrite(0, BASE, 32'hB000_0000 + 32'(i));
        for (int i = 0; i < 10; i++) begin
            busRead(0, BASE);
            checkOutput("wrap_first", data_bus, 32'hB000_0000 + 32'(i));
        end
        for (int i = 0; i < 10; i++) busWrite(0, BASE, 32'hC000_0000 + 32'(i));
        for (int i = 0; i < 10; i++) begin
            busRead(0, BASE);
            checkOutput("wrap_second", data_bus, 32'hC000_0000 + 32'(i));
        end
        busWrite(0, BASE + 2, 32'h3);
        busRead(0, BASE + 1);
        checkOutput("cleared_status", data_bus, 32'h0000_0001);

        $display("[TB] reset during read return");
        #3;
        reset_n     = 1'b0;
        modelReset();
        tb_drive_en = 1'b1;
        tb_data     = 32'h0;
        #1;
        checkOutput("reset_release", data_bus, 32'h0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        tb_data = $urandom;
        busRead(0, BASE + 3);
        checkOutput("reset_thresh", data_bus, 32'h0000_0008);
        busRead(0, BASE + 1);
        checkOutput("reset_count", data_bus, 32'h0000_0001);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1200; i++) begin
            bit          a;
            bit          rdd;
            bit          wrd;
            bit          rdc;
            bit          wrc;
            bit          write_heavy;
            int          sel;
            logic [31:0] addr;
            write_heavy = ((i / 60) % 2) == 0;
            a   = 1'($urandom_range(0, 1));
            rdd = write_heavy ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
            rdc = write_heavy ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
            wrd = write_heavy ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 5) == 0);
            wrc = write_heavy ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 5) == 0);
            sel = $urandom_range(0, 19);
            if (sel < 12)       addr = BASE;
            else if (sel < 14)  addr = BASE + 1;
            else if (sel == 14) addr = BASE + 2;
            else if (sel < 17)  addr = BASE + 3;
            else if (sel < 19)  addr = BASE + 4 + 32'($urandom_range(0, 3));
            else                addr = $urandom;
            if (m_drive) begin
                wrd = 0;
                wrc = 0;
            end
            applyStimulus(a, rdd, wrd, rdc, wrc, addr, $urandom);
        end

        idleCycle();
        idleCycle();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
